// File: rtl/round_sequencer.sv
// round_sequencer
//   Turn controller for the score/coin ALU. Synchronises and edge-detects the
//   player's start/more inputs, captures switch/button operands on each more
//   press and issues them to the ALU over a valid/ready handshake. Counts
//   rounds and flags bust/done for the display path.
//
//   Optional feature macro: ROUND_TIMEOUT_EN
//     defined   -> ISSUE gives up after TIMEOUT cycles without alu_ready and
//                  parks in ERR until the next start.
//     undefined -> ISSUE waits indefinitely; err_o is tied to 0.
//
// Ports
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   start_i      async level: start or restart a game
//   more_i       async level: request the next operation
//   switch_i     [5:0] operand A source
//   button_i     [5:0] operand B source
//   pt_sum_i     [7:0] ALU point total, two BCD digits
//   alu_ready_i  ALU accepts operands this cycle
//   alu_a_o      [5:0] registered operand A
//   alu_b_o      [5:0] registered operand B
//   alu_valid_o  operands valid, held until alu_ready_i
//   alu_clr_o    one-cycle pulse clearing the ALU sums
//   round_cnt_o  [3:0] rounds completed in the current game
//   busy_o       high in ISSUE or CHECK
//   game_over_o  high in BUST or DONE
//   bust_o       high in BUST
//   err_o        high in ERR
module round_sequencer #(
  parameter int         SYNC_STAGES = 2,
  parameter int         MAX_ROUNDS  = 8,
  parameter logic [7:0] LIMIT       = 8'h21
`ifdef ROUND_TIMEOUT_EN
  , parameter int       TIMEOUT     = 15
`endif
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       more_i,
  input  logic [5:0] switch_i,
  input  logic [5:0] button_i,
  input  logic [7:0] pt_sum_i,
  input  logic       alu_ready_i,
  output logic [5:0] alu_a_o,
  output logic [5:0] alu_b_o,
  output logic       alu_valid_o,
  output logic       alu_clr_o,
  output logic [3:0] round_cnt_o,
  output logic       busy_o,
  output logic       game_over_o,
  output logic       bust_o,
  output logic       err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_ISSUE, S_CHECK, S_BUST, S_DONE, S_ERR
  } state_e;

  localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);

  // Input synchronisers followed by a rising-edge detector on the last stage.
  logic [SYNC_STAGES-1:0] start_sync_q, more_sync_q;
  logic                   start_prev_q, more_prev_q;
  logic                   start_p, more_p;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_sync_q <= '0;
      more_sync_q  <= '0;
      start_prev_q <= 1'b0;
      more_prev_q  <= 1'b0;
    end else begin
      start_sync_q <= {start_sync_q[SYNC_STAGES-2:0], start_i};
      more_sync_q  <= {more_sync_q[SYNC_STAGES-2:0], more_i};
      start_prev_q <= start_sync_q[SYNC_STAGES-1];
      more_prev_q  <= more_sync_q[SYNC_STAGES-1];
    end
  end

  assign start_p = start_sync_q[SYNC_STAGES-1] & ~start_prev_q;
  assign more_p  = more_sync_q[SYNC_STAGES-1] & ~more_prev_q;

  // Digit-wise BCD compare; equal to LIMIT is not a bust.
  logic over_limit;
  assign over_limit = (pt_sum_i[7:4] > LIMIT[7:4]) ||
                      ((pt_sum_i[7:4] == LIMIT[7:4]) && (pt_sum_i[3:0] > LIMIT[3:0]));

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [5:0] a_q, a_d, b_q, b_d;
  logic       clr_q, clr_d;
`ifdef ROUND_TIMEOUT_EN
  localparam logic [3:0] TMO = 4'(TIMEOUT);
  logic [3:0] tmo_q, tmo_d;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      clr_q   <= 1'b0;
`ifdef ROUND_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      clr_q   <= clr_d;
`ifdef ROUND_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    clr_d   = 1'b0;
`ifdef ROUND_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    // start wins in every state: it (re)starts or aborts the game, and any
    // coincident more press is dropped.
    if (start_p) begin
      clr_d   = 1'b1;
      cnt_d   = '0;
      state_d = S_WAIT;
    end else begin
      unique case (state_q)
        S_WAIT: if (more_p) begin
          a_d     = switch_i;
          b_d     = button_i;
          state_d = S_ISSUE;
`ifdef ROUND_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
        S_ISSUE: begin
          if (alu_ready_i) begin
            state_d = S_CHECK;
          end
`ifdef ROUND_TIMEOUT_EN
          else begin
            tmo_d = tmo_q + 4'd1;
            if (tmo_d == TMO) state_d = S_ERR;
          end
`endif
        end
        S_CHECK: begin
          cnt_d = cnt_q + 4'd1;
          if (over_limit)          state_d = S_BUST;
          else if (cnt_d == MAX_R) state_d = S_DONE;
          else                     state_d = S_WAIT;
        end
        S_IDLE, S_BUST, S_DONE, S_ERR: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign alu_a_o     = a_q;
  assign alu_b_o     = b_q;
  // Decoded from the state flop so reset removes valid asynchronously.
  assign alu_valid_o = (state_q == S_ISSUE);
  assign alu_clr_o   = clr_q;
  assign round_cnt_o = cnt_q;
  assign busy_o      = (state_q == S_ISSUE) || (state_q == S_CHECK);
  assign game_over_o = (state_q == S_BUST) || (state_q == S_DONE);
  assign bust_o      = (state_q == S_BUST);
`ifdef ROUND_TIMEOUT_EN
  assign err_o       = (state_q == S_ERR);
`else
  assign err_o       = 1'b0;
`endif

endmodule
